// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - ROM fetch sequencer feeding the cpu instr valid/ready port
// Optional macro INSTR_SEQ_JUMP_EN: op 3'b111 becomes a sequencer-consumed JUMP.
module instr_sequencer #(
    parameter int ADDR_W     = 8,
    parameter int INSTR_W    = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  start_pc,
    output logic               imem_rd_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               halted
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [2:0] OP_HALT = 3'b110;
    localparam logic [2:0] OP_JUMP = 3'b111;
`ifdef INSTR_SEQ_JUMP_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_HALTED} state_t;

    state_t             state, state_next;
    logic [ADDR_W-1:0]  pc_next;
    logic               push, pop, not_full;
    logic [2:0]         op;
    logic [INSTR_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign op          = imem_rdata[14:12];
    assign not_full    = count < CNT_W'(FIFO_DEPTH);
    assign instr_valid = count != '0;
    assign pop         = instr_valid && instr_ready;
    assign instr       = instr_valid ? fifo_mem[rd_ptr] : '0;
    assign imem_addr   = pc;
    assign busy        = (state != S_IDLE) && (state != S_HALTED);
    assign halted      = state == S_HALTED;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            pc    <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // ROM data is only meaningful in WAIT, the cycle after the single read strobe.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        push       = 1'b0;
        imem_rd_en = 1'b0;
        case (state)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_next = S_REQ;
                    pc_next    = start_pc;
                end
            end
            S_REQ: begin
                if (not_full) begin
                    imem_rd_en = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (op == OP_HALT) begin
                    state_next = S_DRAIN;
                end else if (JUMP_EN && op == OP_JUMP) begin
                    pc_next    = imem_rdata[ADDR_W-1:0];
                    state_next = S_REQ;
                end else begin
                    push       = 1'b1;
                    pc_next    = pc + 1'b1;
                    state_next = S_REQ;
                end
            end
            S_DRAIN: begin
                if (count == '0) state_next = S_HALTED;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= imem_rdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - randomized scoreboard bench for instr_sequencer
// Honors INSTR_SEQ_JUMP_EN the same way the design does.
module tb_instr_sequencer;
    localparam int ADDR_W = 8, INSTR_W = 16, FIFO_DEPTH = 2;
`ifdef INSTR_SEQ_JUMP_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif

    logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, instr_ready = 1'b0;
    logic [ADDR_W-1:0]  start_pc = '0;
    logic               imem_rd_en, instr_valid, busy, halted;
    logic [ADDR_W-1:0]  imem_addr, pc;
    logic [INSTR_W-1:0] imem_rdata = '0, instr;

    logic [15:0] rom [256];
    logic [15:0] exp_q[$];
    logic [15:0] model_q[$];
    int tests = 0, fails = 0;
    bit mon_en = 1'b0;

    instr_sequencer #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .start_pc(start_pc),
        .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pc(pc), .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (imem_rd_en) imem_rdata <= rom[imem_addr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walk the program as the cpu would see it: HALT stops, JUMP redirects, all else issues.
    task automatic model_run(input logic [7:0] spc, output logic [7:0] end_pc, output bit ok);
        logic [7:0]  p;
        logic [15:0] w;
        p  = spc;
        ok = 1'b0;
        model_q.delete();
        for (int s = 0; s < 200; s++) begin
            w = rom[p];
            if (w[14:12] == 3'b110) begin
                ok = 1'b1;
                break;
            end
            if (JUMP_EN && w[14:12] == 3'b111) begin
                p = w[7:0];
            end else begin
                model_q.push_back(w);
                p = p + 8'd1;
            end
        end
        end_pc = p;
    endtask

    function automatic logic [15:0] plain_word();
        logic [15:0] w;
        w = 16'($urandom);
        w[14:12] = 3'($urandom_range(0, 5));
        return w;
    endfunction

    task automatic wait_halted(input string tag, input bit rand_ready, input logic [7:0] end_pc);
        int cyc;
        cyc = 0;
        while (!halted && cyc < 2000) begin
            instr_ready = rand_ready ? ($urandom % 4 != 0) : 1'b1;
            tick();
            cyc++;
        end
        check_eq({tag, ":halted"}, halted, 1);
        check_eq({tag, ":pc"}, pc, end_pc);
        check_eq({tag, ":drained"}, exp_q.size(), 0);
        check_eq({tag, ":busy"}, busy, 0);
    endtask

    task automatic run_prog(input string tag, input logic [7:0] spc, input bit rand_ready);
        logic [7:0] end_pc;
        bit ok;
        model_run(spc, end_pc, ok);
        foreach (model_q[i]) exp_q.push_back(model_q[i]);
        start_pc = spc;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_halted(tag, rand_ready, end_pc);
    endtask

    // Scoreboard and interface rules, sampled mid-cycle.
    logic [15:0] prev_instr;
    bit prev_hold, prev_rd;
    always @(negedge clk) begin
        if (!reset_n || !mon_en) begin
            prev_hold = 1'b0;
            prev_rd   = 1'b0;
        end else begin
            if (prev_hold) begin
                check_eq("hold_valid", instr_valid, 1);
                check_eq("hold_stable", instr, prev_instr);
            end
            if (prev_rd) check_eq("one_in_flight", imem_rd_en, 0);
            if (!instr_valid) check_eq("instr_zero_empty", instr, 0);
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) check_eq("extra_issue", instr, 32'hdead_beef);
                else check_eq("issue", instr, exp_q.pop_front());
            end
            prev_hold  = instr_valid && !instr_ready;
            prev_instr = instr;
            prev_rd    = imem_rd_en;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] e_pc;
        bit ok;
        foreach (rom[i]) rom[i] = 16'h0000;

        repeat (3) tick();
        check_eq("rst:valid", instr_valid, 0);
        check_eq("rst:instr", instr, 0);
        check_eq("rst:pc", pc, 0);
        check_eq("rst:rd_en", imem_rd_en, 0);
        check_eq("rst:addr", imem_addr, 0);
        check_eq("rst:busy", busy, 0);
        check_eq("rst:halted", halted, 0);
        reset_n = 1'b1;
        tick();
        mon_en = 1'b1;

        // Linear program with first-fetch latency
        rom[8'h10] = 16'h0105; rom[8'h11] = 16'h0203; rom[8'h12] = 16'h6000;
        exp_q.push_back(16'h0105);
        exp_q.push_back(16'h0203);
        instr_ready = 1'b1;
        start_pc = 8'h10;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("lat:rd_en", imem_rd_en, 1);
        check_eq("lat:addr", imem_addr, 8'h10);
        check_eq("lat:busy", busy, 1);
        tick();
        check_eq("lat:wait_rd", imem_rd_en, 0);
        check_eq("lat:wait_valid", instr_valid, 0);
        tick();
        check_eq("lat:valid", instr_valid, 1);
        check_eq("lat:instr", instr, 16'h0105);
        wait_halted("linear", 1'b0, 8'h12);

        // Backpressure, with a start pulse that must be ignored while busy
        for (int i = 0; i < 6; i++) rom[8'h20 + i] = plain_word();
        rom[8'h26] = 16'h6000;
        model_run(8'h20, e_pc, ok);
        foreach (model_q[i]) exp_q.push_back(model_q[i]);
        instr_ready = 1'b0;
        start_pc = 8'h20;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        check_eq("bp:valid", instr_valid, 1);
        check_eq("bp:head", instr, rom[8'h20]);
        start_pc = 8'h80;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("bp:rd_held", imem_rd_en, 0);
            check_eq("bp:busy", busy, 1);
            tick();
        end
        wait_halted("bp", 1'b0, 8'h26);

        // Jump handling (behaviour depends on the build)
        rom[8'h00] = 16'h7040; rom[8'h01] = 16'h6000;
        rom[8'h40] = 16'h3105; rom[8'h41] = 16'h6000;
        run_prog("jump", 8'h00, 1'b0);
        check_eq("jump:end_pc", pc, JUMP_EN ? 8'h41 : 8'h01);

        // PC wrap
        rom[8'hFF] = 16'h0111; rom[8'h00] = 16'h6000;
        run_prog("wrap", 8'hFF, 1'b1);

        // Async reset while a fetch is in flight
        for (int i = 0; i < 6; i++) rom[8'h30 + i] = plain_word();
        rom[8'h36] = 16'h6000;
        instr_ready = 1'b0;
        start_pc = 8'h30;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        mon_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_eq("mrst:valid", instr_valid, 0);
        check_eq("mrst:instr", instr, 0);
        check_eq("mrst:pc", pc, 0);
        check_eq("mrst:busy", busy, 0);
        check_eq("mrst:rd_en", imem_rd_en, 0);
        exp_q.delete();
        tick();
        reset_n = 1'b1;
        tick();
        check_eq("mrst:idle_rd", imem_rd_en, 0);
        mon_en = 1'b1;
        run_prog("mrst_restart", 8'h30, 1'b1);

        // Random programs under random backpressure
        for (int it = 0; it < 15; it++) begin
            logic [7:0] spc;
            ok = 1'b0;
            for (int a = 0; a < 50 && !ok; a++) begin
                foreach (rom[i]) rom[i] = 16'($urandom);
                spc = 8'($urandom);
                model_run(spc, e_pc, ok);
            end
            if (ok) run_prog($sformatf("rand%0d", it), spc, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
